// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcodes, fetch FSM encoding and
// the instruction/PC pair carried between fetch, the skid entry and IF/ID.
package wisc_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;
  localparam logic [4:0] OP_STU  = 5'b10011;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    FS_REQ   = 3'd0,
    FS_WAIT  = 3'd1,
    FS_HOLD  = 3'd2,
    FS_DRAIN = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] inc_pc;
  } fetch_pair_t;

  function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] halt_op);
    return instr[15:11] == halt_op;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// One-entry skid buffer that parks a fetched instruction while decode stalls.
// Clear has priority over load, load over drain.
module if_id_skid
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  fetch_pair_t data_i,
  output fetch_pair_t data_o,
  output logic        valid_o
);

  fetch_pair_t data_q, data_d;
  logic        valid_q, valid_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: a single-entry buffer is plain flops, so its payload is reset too;
  // larger RAM-style storage would reset only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, talks to a multi-cycle instruction
// memory, absorbs decode stalls via a skid entry and squashes on redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR,
  parameter logic [4:0]  HALT_OP   = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_decode,
  input  logic        flush_fetch,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] instr_IF_ID,
  output logic [15:0] inc_pc_IF_ID,
  output logic        valid_IF_ID,
  output logic        halted
);

  import wisc_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  inc_q, inc_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_drain, skid_clear, skid_valid;
  fetch_pair_t  skid_in, skid_out;

  logic [15:0]  pc_plus2;
  logic [15:0]  target;
  logic         req_raw;

  assign pc_plus2 = pc_q + 16'd2;
  assign target   = {branch_target[15:1], 1'b0};
  assign skid_in  = '{instr: imem_rdata, inc_pc: pc_plus2};

  if_id_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .data_i  (skid_in),
    .data_o  (skid_out),
    .valid_o (skid_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    inc_d      = inc_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    req_raw    = 1'b0;

    // Decode consumes IF/ID whenever it is not stalled; without a new
    // instruction the register turns into a bubble.
    if (!stall_decode) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    unique case (state_q)
      FS_REQ, FS_WAIT: begin
        // REQ doubles as a completion cycle for zero-wait memories.
        req_raw = (state_q == FS_WAIT) || !flush_fetch;
        if (imem_done) begin
          pc_d = pc_plus2;
          if (stall_decode) begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
          end else begin
            instr_d = imem_rdata;
            inc_d   = pc_plus2;
            valid_d = 1'b1;
            state_d = is_halt(imem_rdata, HALT_OP) ? FS_HALT : FS_REQ;
          end
        end else if (state_q == FS_REQ) begin
          state_d = FS_WAIT;
        end
      end
      FS_HOLD: begin
        if (!stall_decode && skid_valid) begin
          instr_d    = skid_out.instr;
          inc_d      = skid_out.inc_pc;
          valid_d    = 1'b1;
          skid_drain = 1'b1;
          state_d    = is_halt(skid_out.instr, HALT_OP) ? FS_HALT : FS_REQ;
        end
      end
      FS_DRAIN: begin
        if (imem_done) state_d = FS_REQ;
      end
      FS_HALT: ;
      default: state_d = FS_REQ;
    endcase

    if (flush_fetch) begin
      instr_d    = NOP_INSTR;
      inc_d      = 16'h0000;
      valid_d    = 1'b0;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b1;
      pc_d       = target;
      // An access still in flight must have its response swallowed.
      if ((state_q == FS_WAIT || state_q == FS_DRAIN) && !imem_done)
        state_d = FS_DRAIN;
      else
        state_d = FS_REQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_REQ;
      pc_q    <= {RESET_PC[15:1], 1'b0};
      instr_q <= NOP_INSTR;
      inc_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      inc_q   <= inc_d;
      valid_q <= valid_d;
    end
  end

  // Reset leaves the FSM in REQ; the request is held off until rst_n releases.
  assign imem_req     = req_raw && rst_n;
  assign imem_addr    = {pc_q[15:1], 1'b0};
  assign instr_IF_ID  = instr_q;
  assign inc_pc_IF_ID = inc_q;
  assign valid_IF_ID  = valid_q;
  assign halted       = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural multi-cycle instruction
// memory; expected instructions and PCs are hand-computed constants.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_decode;
  logic        flush_fetch;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic        imem_done  = 1'b0;
  logic [15:0] instr_IF_ID;
  logic [15:0] inc_pc_IF_ID;
  logic        valid_IF_ID;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory word at address a is {1, a[15:1]} so no ordinary word decodes as HALT.
  int          lat       = 1;
  logic [15:0] halt_addr = 16'hFFFF;
  logic        busy      = 1'b0;
  int          cnt       = 0;
  logic [15:0] addr_l    = 16'h0000;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_decode  (stall_decode),
    .flush_fetch   (flush_fetch),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_done     (imem_done),
    .instr_IF_ID   (instr_IF_ID),
    .inc_pc_IF_ID  (inc_pc_IF_ID),
    .valid_IF_ID   (valid_IF_ID),
    .halted        (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return {1'b1, a[15:1]};
  endfunction

  always @(posedge clk) begin
    logic        nd;
    logic [15:0] nr;
    nd = 1'b0;
    nr = 16'hDEAD;
    if (!rst_n) begin
      busy = 1'b0;
    end else if (busy) begin
      cnt = cnt - 1;
      if (cnt <= 0) begin
        nd   = 1'b1;
        nr   = mem_word(addr_l);
        busy = 1'b0;
      end
    end else if (imem_req && !imem_done) begin
      addr_l = imem_addr;
      if (lat <= 1) begin
        nd = 1'b1;
        nr = mem_word(imem_addr);
      end else begin
        busy = 1'b1;
        cnt  = lat - 1;
      end
    end
    #1;
    imem_done  = nd;
    imem_rdata = nr;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] exp_instr,
                            input logic [15:0] exp_inc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (valid_IF_ID) seen = 1'b1;
    end
    check({tag, ".valid"}, {15'd0, valid_IF_ID}, 16'd1);
    check({tag, ".instr"}, instr_IF_ID, exp_instr);
    check({tag, ".inc_pc"}, inc_pc_IF_ID, exp_inc);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, {15'd0, valid_IF_ID}, 16'd0);
    check({tag, ".instr"}, instr_IF_ID, 16'h0800);
    check({tag, ".inc_pc"}, inc_pc_IF_ID, 16'h0000);
  endtask

  initial begin
    stall_decode  = 1'b0;
    flush_fetch   = 1'b0;
    branch_target = 16'h0000;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_bubble("reset");
    check("reset.req", {15'd0, imem_req}, 16'd0);
    check("reset.halted", {15'd0, halted}, 16'd0);

    // 1: sequential fetch from RESET_PC with a single-cycle memory
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("seq.first_addr", imem_addr, 16'h0000);
    wait_valid("seq0", 16'h8000, 16'h0002);
    check("seq.req_after0", {15'd0, imem_req}, 16'd1);
    check("seq.addr_after0", imem_addr, 16'h0002);
    wait_valid("seq1", 16'h8001, 16'h0004);
    wait_valid("seq2", 16'h8002, 16'h0006);

    // 2: stall across a returning response; skid parks it, release in order
    stall_decode = 1'b1;
    step();
    check("stall.hold_instr", instr_IF_ID, 16'h8002);
    check("stall.hold_valid", {15'd0, valid_IF_ID}, 16'd1);
    step();
    check("stall.skid_instr", instr_IF_ID, 16'h8002);
    check("stall.no_req", {15'd0, imem_req}, 16'd0);
    step();
    check("stall.hold_inc", inc_pc_IF_ID, 16'h0006);
    check("stall.no_req2", {15'd0, imem_req}, 16'd0);
    stall_decode = 1'b0;
    step();
    check("release.instr", instr_IF_ID, 16'h8003);
    check("release.inc_pc", inc_pc_IF_ID, 16'h0008);
    check("release.valid", {15'd0, valid_IF_ID}, 16'd1);
    wait_valid("after_release", 16'h8004, 16'h000A);

    // 3: flush during WAIT with a slow memory; one response is drained
    lat = 3;
    step();
    flush_fetch   = 1'b1;
    branch_target = 16'h0041;
    step();
    flush_fetch = 1'b0;
    check_bubble("flush_wait");
    check("drain.no_req", {15'd0, imem_req}, 16'd0);
    step();
    check("drain.no_req2", {15'd0, imem_req}, 16'd0);
    step();
    check("drain.req", {15'd0, imem_req}, 16'd1);
    check("drain.addr", imem_addr, 16'h0040);
    check("drain.dropped", {15'd0, valid_IF_ID}, 16'd0);
    lat = 1;
    wait_valid("target", 16'h8020, 16'h0042);

    // 4: flush and stall together; flush wins
    stall_decode  = 1'b1;
    flush_fetch   = 1'b1;
    branch_target = 16'h0100;
    step();
    stall_decode = 1'b0;
    flush_fetch  = 1'b0;
    check_bubble("flush_stall");
    check("flush_stall.addr", imem_addr, 16'h0100);
    wait_valid("fs0", 16'h8080, 16'h0102);

    // 5: HALT stops fetching until a flush restarts it
    halt_addr = 16'h0104;
    wait_valid("fs1", 16'h8081, 16'h0104);
    wait_valid("halt", 16'h0000, 16'h0106);
    check("halt.halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt.no_req", {15'd0, imem_req}, 16'd0);
    end
    check("halt.still", {15'd0, halted}, 16'd1);
    halt_addr     = 16'hFFFF;
    flush_fetch   = 1'b1;
    branch_target = 16'h0010;
    step();
    flush_fetch = 1'b0;
    check("restart.halted", {15'd0, halted}, 16'd0);
    check("restart.addr", imem_addr, 16'h0010);
    wait_valid("restart", 16'h8008, 16'h0012);

    // 6: PC wrap at 16'hFFFE, then asynchronous reset in the middle of WAIT
    flush_fetch   = 1'b1;
    branch_target = 16'hFFFE;
    step();
    flush_fetch = 1'b0;
    wait_valid("wrap", 16'hFFFF, 16'h0000);
    check("wrap.addr", imem_addr, 16'h0000);
    stall_decode = 1'b1;
    step();
    check("pre_reset.valid", {15'd0, valid_IF_ID}, 16'd1);
    rst_n = 1'b0;
    #1;
    check_bubble("async_reset");
    check("async_reset.req", {15'd0, imem_req}, 16'd0);
    check("async_reset.halted", {15'd0, halted}, 16'd0);
    stall_decode = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_valid("post_reset", 16'h8000, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
